// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: request/address/write-data out, ack/read-data back.
interface mem_stage_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_ack, mem_rdata
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: aligned loads/stores with wait-state stall, 4-bit timeout,
// misalignment trap, forwarding taps and the MEM/WB register.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic        WB_EN_in,
   input  logic        MEM_R_EN_in,
   input  logic        MEM_W_EN_in,
   input  logic        MEM_TO_REG_in,
   input  logic [31:0] alu_result,
   input  logic [31:0] store_data,
   input  logic [4:0]  regD_in,
   mem_stage_if.master mem,
   output logic        stall,
   output logic        align_err,
   output logic        bus_err,
   output logic [31:0] regFromMem,
   output logic [4:0]  mem_regD,
   output logic        RegW_en_mem,
   output logic        WB_EN,
   output logic        MEM_TO_REG,
   output logic [31:0] mem_data,
   output logic [31:0] alu_data,
   output logic [4:0]  regD
);
   typedef enum logic {IDLE, BUSY} state_t;

   state_t     state, state_nx;
   logic [3:0] cnt, cnt_nx;
   logic       access, misalign, pending, rd_only;
   logic       req, stall_c, berr_c, done;

   assign access   = MEM_R_EN_in | MEM_W_EN_in;
   assign misalign = access & (alu_result[1:0] != 2'b00);
   assign pending  = access & ~misalign;
   assign rd_only  = MEM_R_EN_in & ~MEM_W_EN_in;

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      req      = 1'b0;
      stall_c  = 1'b0;
      berr_c   = 1'b0;
      done     = 1'b0;
      case (state)
         IDLE: begin
            if (pending) begin
               req = 1'b1;
               if (mem.mem_ack) begin
                  done = 1'b1;
               end else begin
                  stall_c  = 1'b1;
                  state_nx = BUSY;
                  cnt_nx   = 4'd1;
               end
            end
         end
         BUSY: begin
            req = 1'b1;
            if (mem.mem_ack) begin
               done     = 1'b1;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else if (cnt == 4'd15) begin
               berr_c   = 1'b1;
               state_nx = IDLE;
               cnt_nx   = '0;
            end else begin
               stall_c = 1'b1;
               cnt_nx  = cnt + 4'd1;
            end
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   // Request and pipeline-control pulses are masked while reset is held low.
   assign mem.mem_req   = req & reset;
   assign mem.mem_we    = MEM_W_EN_in;
   assign mem.mem_addr  = alu_result;
   assign mem.mem_wdata = store_data;

   assign stall     = stall_c & reset;
   assign bus_err   = berr_c & reset;
   assign align_err = misalign & (state == IDLE) & reset;

   assign regFromMem  = alu_result;
   assign mem_regD    = regD_in;
   assign RegW_en_mem = WB_EN_in & ~MEM_TO_REG_in & ~stall;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         cnt        <= '0;
         WB_EN      <= 1'b0;
         MEM_TO_REG <= 1'b0;
         mem_data   <= '0;
         alu_data   <= '0;
         regD       <= '0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (stall_c) begin
            WB_EN <= 1'b0;
         end else begin
            WB_EN      <= WB_EN_in & ~misalign & ~berr_c;
            MEM_TO_REG <= MEM_TO_REG_in;
            alu_data   <= alu_result;
            regD       <= regD_in;
            if (done && rd_only) begin
               mem_data <= mem.mem_rdata;
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: driver predicts per-cycle behaviour and
// WB contents from access latency rules; a negedge monitor compares.
module tb_mem_stage;
   logic        clk = 1'b0;
   logic        reset;
   logic        WB_EN_in, MEM_R_EN_in, MEM_W_EN_in, MEM_TO_REG_in;
   logic [31:0] alu_result, store_data;
   logic [4:0]  regD_in;
   logic        stall, align_err, bus_err;
   logic [31:0] regFromMem;
   logic [4:0]  mem_regD;
   logic        RegW_en_mem;
   logic        WB_EN, MEM_TO_REG;
   logic [31:0] mem_data, alu_data;
   logic [4:0]  regD;

   mem_stage_if mif();

   mem_stage dut (
      .clk(clk), .reset(reset),
      .WB_EN_in(WB_EN_in), .MEM_R_EN_in(MEM_R_EN_in), .MEM_W_EN_in(MEM_W_EN_in),
      .MEM_TO_REG_in(MEM_TO_REG_in), .alu_result(alu_result), .store_data(store_data),
      .regD_in(regD_in), .mem(mif),
      .stall(stall), .align_err(align_err), .bus_err(bus_err),
      .regFromMem(regFromMem), .mem_regD(mem_regD), .RegW_en_mem(RegW_en_mem),
      .WB_EN(WB_EN), .MEM_TO_REG(MEM_TO_REG), .mem_data(mem_data),
      .alu_data(alu_data), .regD(regD)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wb_en;
      logic        m2r;
      logic [31:0] alu;
      logic [31:0] mdata;
      logic [4:0]  rd;
   } wb_t;

   wb_t         exp_q[$];
   wb_t         last_wb;
   logic [31:0] model_mdata;
   int unsigned n_chk = 0;
   int unsigned n_fail = 0;

   // Per-cycle expectations published by the driver for the monitor.
   logic in_valid = 1'b0;
   int   cyc = 0;
   logic e_stall, e_req, e_align, e_berr, e_we;
   logic check_next = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      wb_t e;
      if (check_next) begin
         check_next = 1'b0;
         if (exp_q.size() == 0) begin
            chk("sb_underflow", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("wb_en", WB_EN, e.wb_en);
            chk("wb_m2r", MEM_TO_REG, e.m2r);
            chk("wb_alu", alu_data, e.alu);
            chk("wb_rd", regD, e.rd);
            chk("wb_mdata", mem_data, e.mdata);
            last_wb = e;
         end
      end else if (in_valid && cyc > 0) begin
         chk("bubble_wb_en", WB_EN, 0);
         chk("bubble_alu_hold", alu_data, last_wb.alu);
         chk("bubble_rd_hold", regD, last_wb.rd);
         chk("bubble_mdata_hold", mem_data, last_wb.mdata);
      end
      if (in_valid) begin
         chk("stall", stall, e_stall);
         chk("mem_req", mif.mem_req, e_req);
         chk("align_err", align_err, e_align);
         chk("bus_err", bus_err, e_berr);
         if (e_req) begin
            chk("mem_addr", mif.mem_addr, alu_result);
            chk("mem_wdata", mif.mem_wdata, store_data);
            chk("mem_we", mif.mem_we, e_we);
         end
         chk("fwd_data", regFromMem, alu_result);
         chk("fwd_rd", mem_regD, regD_in);
         chk("fwd_wen", RegW_en_mem, WB_EN_in & ~MEM_TO_REG_in & ~e_stall);
         if (!stall) check_next = 1'b1;
      end
   end

   // k = cycle index (0 = issue cycle) at which memory acks; k > 15 means never.
   task automatic issue(input logic r, input logic w, input logic wben, input logic m2r,
                        input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input int k);
      logic        acc, mis, pend, tout;
      int          last;
      logic [31:0] ack_data;
      wb_t         e;
      acc  = r | w;
      mis  = acc && (alu[1:0] != 2'b00);
      pend = acc && !mis;
      tout = pend && (k > 15);
      last = pend ? ((k < 15) ? k : 15) : 0;
      ack_data = $urandom;
      e.wb_en = wben & ~mis & ~tout;
      e.m2r   = m2r;
      e.alu   = alu;
      e.rd    = rd;
      if (pend && r && !w && !tout) model_mdata = ack_data;
      e.mdata = model_mdata;
      exp_q.push_back(e);

      WB_EN_in = wben; MEM_R_EN_in = r; MEM_W_EN_in = w; MEM_TO_REG_in = m2r;
      alu_result = alu; store_data = sd; regD_in = rd;
      in_valid = 1'b1;
      for (int c = 0; c <= last; c++) begin
         cyc = c;
         if (pend) begin
            mif.mem_ack   = (c == k);
            mif.mem_rdata = (c == k) ? ack_data : $urandom;
         end else begin
            mif.mem_ack   = 1'($urandom_range(0, 1));
            mif.mem_rdata = $urandom;
         end
         e_stall = pend && (c < last);
         e_req   = pend;
         e_align = mis;
         e_berr  = tout && (c == 15);
         e_we    = w;
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; MEM_TO_REG_in = 0;
      alu_result = '0; store_data = '0; regD_in = '0;
      mif.mem_ack = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      chk("sb_drained", exp_q.size(), 0);
   endtask

   task automatic chk_wb_zero(input string tag);
      chk({tag, "_wb_en"}, WB_EN, 0);
      chk({tag, "_m2r"}, MEM_TO_REG, 0);
      chk({tag, "_rd"}, regD, 0);
      chk({tag, "_alu"}, alu_data, 0);
      chk({tag, "_mdata"}, mem_data, 0);
   endtask

   initial begin
      int          t, k;
      logic        r, w;
      logic [31:0] a;
      reset = 1'b0;
      WB_EN_in = 0; MEM_R_EN_in = 0; MEM_W_EN_in = 0; MEM_TO_REG_in = 0;
      alu_result = '0; store_data = '0; regD_in = '0;
      mif.mem_ack = 1'b0; mif.mem_rdata = '0;
      model_mdata = '0;
      last_wb = '{default: '0};
      repeat (2) begin @(posedge clk); #1; end
      chk_wb_zero("rst");
      // A pending aligned read while reset is low must not request or stall.
      MEM_R_EN_in = 1; alu_result = 32'h40; #1;
      chk("rst_req", mif.mem_req, 0);
      chk("rst_stall", stall, 0);
      chk("rst_align", align_err, 0);
      chk("rst_berr", bus_err, 0);
      MEM_R_EN_in = 0; alu_result = '0;
      @(posedge clk); #1;
      reset = 1'b1;
      #1;
      chk("post_rst_stall", stall, 0);
      chk("post_rst_berr", bus_err, 0);

      // Directed scenarios.
      issue(1, 0, 1, 1, 32'h100, 32'h0, 5'd5, 0);          // zero-wait load
      issue(0, 1, 0, 0, 32'h200, 32'h12345678, 5'd9, 3);   // 3-wait store
      issue(1, 0, 1, 1, 32'h102, 32'h0, 5'd3, 0);          // misaligned
      issue(1, 0, 1, 1, 32'h104, 32'h0, 5'd4, 99);         // timeout
      issue(0, 0, 1, 0, 32'h55, 32'h0, 5'd7, 0);           // forwarding ALU op
      issue(1, 1, 1, 0, 32'h300, 32'hA5A5A5A5, 5'd8, 1);   // both enables = write
      issue(1, 0, 1, 1, 32'h304, 32'h0, 5'd2, 15);         // ack on the last allowed cycle
      drain();

      for (int i = 0; i < 300; i++) begin
         t = $urandom_range(0, 9);
         a = $urandom;
         r = 0; w = 0; k = $urandom_range(0, 4);
         if (t >= 4) begin
            r = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1;
            if (t == 8) a[1:0] = 2'($urandom_range(1, 3));
            else        a[1:0] = 2'b00;
            if (t == 9) begin
               case ($urandom_range(0, 3))
                  0: k = 14;
                  1: k = 15;
                  2: k = 16;
                  default: k = 40;
               endcase
            end
         end
         issue(r, w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
               5'($urandom_range(0, 31)), k);
      end
      drain();

      // Reset on the second wait cycle of a read that never acks.
      WB_EN_in = 1; MEM_R_EN_in = 1; MEM_TO_REG_in = 1; alu_result = 32'h3F0; regD_in = 5'd11;
      mif.mem_ack = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("busy_stall", stall, 1);
      reset = 1'b0;
      WB_EN_in = 0; MEM_R_EN_in = 0; MEM_TO_REG_in = 0; alu_result = '0; regD_in = '0;
      mif.mem_ack = 1'b1;
      @(posedge clk); #1;
      chk("midrst_req", mif.mem_req, 0);
      chk("midrst_berr", bus_err, 0);
      chk("midrst_stall", stall, 0);
      chk_wb_zero("midrst");
      reset = 1'b1;
      @(posedge clk); #1;
      chk("late_ack_req", mif.mem_req, 0);
      chk("late_ack_stall", stall, 0);
      chk("late_ack_berr", bus_err, 0);
      chk_wb_zero("late_ack");
      mif.mem_ack = 1'b0;
      model_mdata = '0;
      last_wb = '{default: '0};

      // The stage must be fully usable after the abandoned access.
      issue(1, 0, 1, 1, 32'h500, 32'h0, 5'd6, 2);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
